phase_inc_sweep_rx: RTL and testbench

AXI4-Stream slave that consumes the swept phase-increment stream from the DDS phase-increment source (32-bit increment, `tvalid`/`tready`, out-of-band `tlast` dwell marker). It accepts each increment word, drives a free-running phase accumulator from it, and reports sweep-level telemetry: steps per sweep, sweep wrap, and dwell length between `tlast` markers. It sits between the increment generator and the downstream phase-to-amplitude stage or monitor logic, and is the receiving end of the same stream.

---
 rtl/phase_inc_sweep_rx.sv | 160 ++++++++++++++++
 tb/tb_phase_inc_sweep_rx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_inc_sweep_rx.sv
// Receiving end of the swept phase-increment stream: phase accumulator,
// sweep step/wrap telemetry and tlast dwell measurement.
module phase_inc_sweep_rx #(
    parameter int PHASE_W = 32,
    parameter int HOLDOFF = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PHASE_W-1:0] s_axis_phase_tdata,
    input  logic               s_axis_phase_tvalid,
    output logic               s_axis_phase_tready,
    input  logic               s_axis_phase_tlast,
    output logic [PHASE_W-1:0] phase_out,
    output logic               phase_valid,
    output logic [PHASE_W-1:0] cur_inc,
    output logic [15:0]        step_count,
    output logic               sweep_wrap,
    output logic [31:0]        dwell_cycles,
    output logic               tlast_pulse
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {IDLE, READY, HOLD} state_t;

    state_t             state_q, state_d;
    logic               tready_q, tready_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic               have_inc_q, have_inc_d;
    logic [PHASE_W-1:0] cur_inc_q, cur_inc_d;
    logic [15:0]        step_q, step_d;
    logic               wrap_q, wrap_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               pvalid_q, pvalid_d;
    logic [31:0]        dwell_cnt_q, dwell_cnt_d;
    logic [31:0]        dwell_q, dwell_d;
    logic               tpulse_q, tpulse_d;
    logic               tlast_q, tlast_d;

    logic               accept;
    logic               rise;
    logic [31:0]        dwell_inc;

    always_comb begin
        accept      = s_axis_phase_tvalid && tready_q;
        rise        = s_axis_phase_tlast && !tlast_q;
        dwell_inc   = (&dwell_cnt_q) ? dwell_cnt_q : dwell_cnt_q + 32'd1;

        state_d     = state_q;
        tready_d    = tready_q;
        hold_cnt_d  = hold_cnt_q;
        have_inc_d  = have_inc_q;
        cur_inc_d   = cur_inc_q;
        step_d      = step_q;
        wrap_d      = 1'b0;
        phase_d     = phase_q;
        pvalid_d    = enable && have_inc_q;
        tlast_d     = s_axis_phase_tlast;
        tpulse_d    = rise;
        dwell_q_hold: begin end
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_inc;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = READY;
                    tready_d = 1'b1;
                end
            end
            READY: begin
                if (accept && HOLDOFF > 0) begin
                    state_d    = HOLD;
                    tready_d   = 1'b0;
                    hold_cnt_d = HOLD_LOAD;
                end else if (!enable) begin
                    state_d  = IDLE;
                    tready_d = 1'b0;
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d  = enable ? READY : IDLE;
                    tready_d = enable;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                tready_d = 1'b0;
            end
        endcase

        if (accept) begin
            cur_inc_d  = s_axis_phase_tdata;
            have_inc_d = 1'b1;
            if (have_inc_q && (s_axis_phase_tdata < cur_inc_q)) begin
                wrap_d = 1'b1;
                step_d = 16'd1;
            end else if (step_q != 16'hFFFF) begin
                step_d = step_q + 16'd1;
            end
        end

        if (enable && have_inc_q) begin
            phase_d = phase_q + cur_inc_q;
        end

        // The capture includes the rise edge itself, so rises N cycles apart read N.
        if (rise) begin
            dwell_d     = dwell_inc;
            dwell_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tready_q    <= 1'b0;
            hold_cnt_q  <= '0;
            have_inc_q  <= 1'b0;
            cur_inc_q   <= '0;
            step_q      <= '0;
            wrap_q      <= 1'b0;
            phase_q     <= '0;
            pvalid_q    <= 1'b0;
            dwell_cnt_q <= '0;
            dwell_q     <= '0;
            tpulse_q    <= 1'b0;
            tlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tready_q    <= tready_d;
            hold_cnt_q  <= hold_cnt_d;
            have_inc_q  <= have_inc_d;
            cur_inc_q   <= cur_inc_d;
            step_q      <= step_d;
            wrap_q      <= wrap_d;
            phase_q     <= phase_d;
            pvalid_q    <= pvalid_d;
            dwell_cnt_q <= dwell_cnt_d;
            dwell_q     <= dwell_d;
            tpulse_q    <= tpulse_d;
            tlast_q     <= tlast_d;
        end
    end

    assign s_axis_phase_tready = tready_q;
    assign phase_out           = phase_q;
    assign phase_valid         = pvalid_q;
    assign cur_inc             = cur_inc_q;
    assign step_count          = step_q;
    assign sweep_wrap          = wrap_q;
    assign dwell_cycles        = dwell_q;
    assign tlast_pulse         = tpulse_q;

endmodule

// File: tb/tb_phase_inc_sweep_rx.sv
// Bench for phase_inc_sweep_rx: directed steps plus random traffic
// compared against an arithmetic reference model.
module tb_phase_inc_sweep_rx;

    localparam int H = 2;

    logic        clk = 1'b0;
    logic        reset, en, tv, tl;
    logic [31:0] td;
    logic        tready, pvalid, wrap, tpulse;
    logic [31:0] phase_out, cur_inc, dwell;
    logic [15:0] steps;

    logic        en0, tv0;
    logic [31:0] td0;
    logic        tready0, pvalid0, wrap0, tpulse0;
    logic [31:0] phase0, cur_inc0, dwell0;
    logic [15:0] steps0;
    logic        tl0 = 1'b0;

    always #5 clk = ~clk;

    phase_inc_sweep_rx #(.PHASE_W(32), .HOLDOFF(H)) dut (
        .clk(clk), .reset(reset), .enable(en),
        .s_axis_phase_tdata(td), .s_axis_phase_tvalid(tv),
        .s_axis_phase_tready(tready), .s_axis_phase_tlast(tl),
        .phase_out(phase_out), .phase_valid(pvalid), .cur_inc(cur_inc),
        .step_count(steps), .sweep_wrap(wrap),
        .dwell_cycles(dwell), .tlast_pulse(tpulse)
    );

    phase_inc_sweep_rx #(.PHASE_W(32), .HOLDOFF(0)) dut0 (
        .clk(clk), .reset(reset), .enable(en0),
        .s_axis_phase_tdata(td0), .s_axis_phase_tvalid(tv0),
        .s_axis_phase_tready(tready0), .s_axis_phase_tlast(tl0),
        .phase_out(phase0), .phase_valid(pvalid0), .cur_inc(cur_inc0),
        .step_count(steps0), .sweep_wrap(wrap0),
        .dwell_cycles(dwell0), .tlast_pulse(tpulse0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (HOLDOFF = H instance)
    logic [31:0] m_phase, m_inc, m_dwell;
    bit          m_have, m_wrap, m_ready, m_pvalid, m_tpulse, m_tl_prev;
    int          m_steps, m_hold_left;
    int unsigned m_edge, m_last_rise;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = '0; m_inc = '0; m_dwell = '0;
        m_have = 0; m_wrap = 0; m_ready = 0; m_pvalid = 0;
        m_tpulse = 0; m_tl_prev = 0;
        m_steps = 0; m_hold_left = 0;
        m_edge = 0; m_last_rise = 0;
    endtask

    task automatic model_edge();
        bit acc, rise;
        acc  = tv && m_ready;
        rise = tl && !m_tl_prev;
        m_edge++;
        m_pvalid = en && m_have;
        if (en && m_have) m_phase = m_phase + m_inc;
        m_wrap = 0;
        if (acc) begin
            if (m_have && td < m_inc) begin
                m_wrap  = 1;
                m_steps = 1;
            end else begin
                m_steps = (m_steps >= 65535) ? 65535 : m_steps + 1;
            end
            m_inc  = td;
            m_have = 1;
        end
        if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_ready = en;
        end else if (acc && H > 0) begin
            m_ready     = 0;
            m_hold_left = H;
        end else begin
            m_ready = en;
        end
        m_tpulse = rise;
        if (rise) begin
            m_dwell     = m_edge - m_last_rise;
            m_last_rise = m_edge;
        end
        m_tl_prev = tl;
    endtask

    task automatic check_all();
        chk("tready", tready, 64'(m_ready));
        chk("phase_out", phase_out, m_phase);
        chk("phase_valid", pvalid, 64'(m_pvalid));
        chk("cur_inc", cur_inc, m_inc);
        chk("step_count", steps, 64'(m_steps));
        chk("sweep_wrap", wrap, 64'(m_wrap));
        chk("dwell_cycles", dwell, m_dwell);
        chk("tlast_pulse", tpulse, 64'(m_tpulse));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic accept_word(input logic [31:0] w);
        bit done = 0;
        td = w;
        tv = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            done = m_ready;
            tick();
        end
        tv = 1'b0;
        chk("accept_in_time", 64'(done), 64'd1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !m_ready; i++) tick();
        chk("ready_in_time", tready, 64'd1);
    endtask

    logic [31:0] sweep_w [4] = '{32'h3531DEC0, 32'h36D7D3A2, 32'h3884FCAC, 32'h3531DEC0};
    int          sweep_s [4] = '{1, 2, 3, 1};
    bit          sweep_p [4] = '{0, 0, 0, 1};

    initial begin
        int acc_cnt;
        int npulse;
        logic [31:0] frozen;

        reset = 1'b1; en = 1'b1; tv = 1'b0; tl = 1'b0; td = '0;
        en0 = 1'b1; tv0 = 1'b0; td0 = '0;
        model_reset();

        // Reset: everything zero on both instances
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_tready0", tready0, 64'd0);
            chk("rst_phase0", phase0, 64'd0);
            chk("rst_pvalid0", pvalid0, 64'd0);
            chk("rst_cur_inc0", cur_inc0, 64'd0);
            chk("rst_steps0", steps0, 64'd0);
            chk("rst_wrap0", wrap0, 64'd0);
            chk("rst_dwell0", dwell0, 64'd0);
            chk("rst_tpulse0", tpulse0, 64'd0);
        end
        chk("rst_tready", tready, 64'd0);
        reset = 1'b0;
        tick();
        chk("tready_after_first_edge", tready, 64'd1);

        // Accumulator
        accept_word(32'h00551C97);
        chk("acc_cur_inc", cur_inc, 64'h00551C97);
        tick(); chk("acc_phase1", phase_out, 64'h00551C97);
        tick(); chk("acc_phase2", phase_out, 64'h00AA392E);
        tick(); chk("acc_phase3", phase_out, 64'h00FF55C5);
        accept_word(32'h80000000);
        accept_word(32'h80000000);
        chk("equal_no_wrap", wrap, 64'd0);
        for (int i = 0; i < 4; i++) tick();

        // Holdoff throughput on both instances
        wait_ready();
        acc_cnt = 0;
        tv = 1'b1;
        for (int k = 0; k < 18; k++) begin
            chk("tready_pattern", tready, 64'(k % 3 == 0));
            if (k < 6) chk("h0_tready", tready0, 64'd1);
            acc_cnt += int'(tready);
            td  = 32'h1000 + 32'(k);
            tv0 = (k < 6);
            td0 = 32'(k + 1);
            tick();
            if (k < 6) chk("h0_steps", steps0, 64'(k + 1));
        end
        tv = 1'b0; tv0 = 1'b0;
        chk("h2_accepts", 64'(acc_cnt), 64'd6);
        chk("h0_total", steps0, 64'd6);

        // Enable dropped during HOLD
        wait_ready();
        accept_word($urandom());
        chk("hold_entered", tready, 64'd0);
        en = 1'b0;
        frozen = m_phase;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_tready", tready, 64'd0);
        end
        chk("phase_frozen", phase_out, frozen);
        chk("pvalid_off", pvalid, 64'd0);

        // Reset with a pending handshake
        en = 1'b1;
        wait_ready();
        td = $urandom() | 32'h1;
        tv = 1'b1;
        reset = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_cur_inc", cur_inc, 64'd0);
        chk("mid_rst_steps", steps, 64'd0);
        chk("mid_rst_tready", tready, 64'd0);
        tick();
        tv = 1'b0;
        reset = 1'b0;
        tick();

        // Sweep wrap
        for (int i = 0; i < 4; i++) begin
            accept_word(sweep_w[i]);
            chk("sweep_steps", steps, 64'(sweep_s[i]));
            chk("sweep_pulse", wrap, 64'(sweep_p[i]));
        end
        tick();
        chk("wrap_one_cycle", wrap, 64'd0);
        accept_word(32'h3531DEC0);
        chk("repeat_no_wrap", wrap, 64'd0);
        chk("repeat_steps", steps, 64'd2);

        // Dwell: rises 80 cycles apart, 3 cycles high each
        npulse = 0;
        for (int c = 0; c < 100; c++) begin
            tl = (c >= 10 && c < 13) || (c >= 90 && c < 93);
            tick();
            npulse += int'(tpulse);
        end
        tl = 1'b0;
        chk("tlast_pulses", 64'(npulse), 64'd2);
        chk("dwell_80", dwell, 64'd80);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            en    = ($urandom_range(0, 9) != 0);
            tv    = $urandom_range(0, 1) == 1;
            td    = ($urandom_range(0, 1) == 1) ? $urandom()
                                                : (32'($urandom_range(0, 7)) << 28);
            if ($urandom_range(0, 7) == 0) tl = ~tl;
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule
